// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, REQ/WAIT/IDLE fetch FSM and instruction register.
// Optional macro FETCH_MISALIGN_CHECK_EN rejects a misaligned next PC and raises misalign.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        misalign
);

  localparam logic [1:0]  ST_REQ  = 2'd0;
  localparam logic [1:0]  ST_WAIT = 2'd1;
  localparam logic [1:0]  ST_IDLE = 2'd2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] cand_s;
  logic [31:0] instr_r;
  logic        req_r;
  logic        instr_valid_r;
  logic        busy_r;
  logic        misalign_r;
  logic        misalign_s;
  logic        load_s;

  function automatic logic [31:0] next_pc_f(input logic [31:0] cur, input logic sel,
                                            input logic [31:0] tgt);
    next_pc_f = sel ? tgt : cur + 32'd4;
  endfunction

  // Next-state, next-PC and instruction-load decode.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    misalign_s = misalign_r;
    load_s     = 1'b0;
    cand_s     = next_pc_f(pc_r, pc_sel, pc_target);
    case (state_r)
      ST_REQ: begin
        // req_r is low only in the first cycle after reset, before the request is visible.
        if (req_r && imem_gnt) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_s = ST_IDLE;
          load_s  = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_IDLE: begin
        if (pc_inc) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (cand_s[1:0] != 2'b00) begin
            misalign_s = 1'b1;
            state_s    = ST_IDLE;
          end else begin
            pc_s       = cand_s;
            misalign_s = 1'b0;
            state_s    = ST_REQ;
          end
`else
          pc_s       = cand_s & 32'hFFFF_FFFC;
          misalign_s = 1'b0;
          state_s    = ST_REQ;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_REQ;
      end
    endcase
  end

  // State, PC, instruction register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_REQ;
      pc_r          <= RESET_PC;
      instr_r       <= NOP;
      instr_valid_r <= 1'b0;
      req_r         <= 1'b0;
      busy_r        <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      instr_r       <= load_s ? imem_rdata : instr_r;
      instr_valid_r <= load_s;
      req_r         <= (state_s == ST_REQ);
      busy_r        <= (state_s != ST_IDLE);
      misalign_r    <= misalign_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign busy        = busy_r;
  assign misalign    = misalign_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus randomized fetches against a PC/instr model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_inc;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_mis;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_inc     (pc_inc),
    .pc_sel     (pc_sel),
    .pc_target  (pc_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .busy       (busy),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enters on the first cycle imem_req is visible; leaves in IDLE one cycle after instr_valid.
  task automatic fetch(input int gw, input int rw, input logic [31:0] data, input bit wait_inc);
    for (int i = 0; i < gw; i++) begin
      chk1("req_hold", imem_req, 1'b1);
      chk32("addr_hold", imem_addr, exp_pc);
      chk32("instr_hold", instr, exp_instr);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'($urandom);
      imem_rdata  = $urandom;
      pc_inc      = 1'($urandom);
      pc_sel      = 1'($urandom);
      pc_target   = $urandom;
      tick();
    end
    chk1("req", imem_req, 1'b1);
    chk32("addr", imem_addr, exp_pc);
    chk1("busy_req", busy, 1'b1);
    chk1("mis_req", misalign, exp_mis);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'($urandom);
    imem_rdata  = $urandom;
    pc_inc      = 1'($urandom);
    tick();
    for (int j = 0; j < rw; j++) begin
      chk1("wait_req", imem_req, 1'b0);
      chk1("wait_busy", busy, 1'b1);
      chk32("wait_pc", pc, exp_pc);
      chk32("wait_instr", instr, exp_instr);
      imem_gnt    = 1'($urandom);
      imem_rvalid = 1'b0;
      pc_inc      = wait_inc ? 1'b1 : 1'($urandom);
      pc_sel      = 1'($urandom);
      pc_target   = $urandom;
      tick();
    end
    chk1("wait_req", imem_req, 1'b0);
    chk1("wait_valid", instr_valid, 1'b0);
    imem_gnt    = 1'($urandom);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    pc_inc      = wait_inc ? 1'b1 : 1'($urandom);
    pc_sel      = 1'($urandom);
    pc_target   = $urandom;
    tick();
    exp_instr = data;
    chk1("valid_pulse", instr_valid, 1'b1);
    chk32("instr_load", instr, exp_instr);
    chk32("pc_load", pc, exp_pc);
    chk1("busy_idle", busy, 1'b0);
    chk1("req_idle", imem_req, 1'b0);
    pc_inc      = 1'b0;
    imem_gnt    = 1'($urandom);
    imem_rvalid = 1'($urandom);
    imem_rdata  = $urandom;
    pc_sel      = 1'($urandom);
    pc_target   = $urandom;
    tick();
    chk1("valid_drop", instr_valid, 1'b0);
    chk32("instr_stable", instr, exp_instr);
    chk32("pc_stable", pc, exp_pc);
    chk1("req_stays_low", imem_req, 1'b0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  // Issues one pc_inc from IDLE and checks the resulting request (or rejection).
  task automatic advance(input logic sel, input logic [31:0] tgt, output bit go);
    logic [31:0] nxt;
    nxt         = sel ? tgt : exp_pc + 32'd4;
    pc_inc      = 1'b1;
    pc_sel      = sel;
    pc_target   = tgt;
    imem_gnt    = 1'($urandom);
    imem_rvalid = 1'($urandom);
    tick();
    pc_inc      = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    go = (nxt[1:0] == 2'b00);
    if (go) begin
      exp_pc  = nxt;
      exp_mis = 1'b0;
    end else begin
      exp_mis = 1'b1;
    end
`else
    go      = 1'b1;
    exp_pc  = {nxt[31:2], 2'b00};
    exp_mis = 1'b0;
`endif
    chk1("adv_req", imem_req, go);
    chk1("adv_busy", busy, go);
    chk32("adv_pc", pc, exp_pc);
    chk1("adv_mis", misalign, exp_mis);
    if (go) chk32("adv_addr", imem_addr, exp_pc);
  endtask

  initial begin
    bit go;
    logic [31:0] tgt;
    rst         = 1'b1;
    pc_inc      = 1'b0;
    pc_sel      = 1'b0;
    pc_target   = 32'h0000_0000;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    exp_pc      = 32'h0000_0000;
    exp_instr   = 32'h0000_0013;
    exp_mis     = 1'b0;

    // Reset values while rst is held.
    tick();
    tick();
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_pc", pc, 32'h0000_0000);
    chk32("rst_instr", instr, 32'h0000_0013);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_mis", misalign, 1'b0);
    rst      = 1'b0;
    imem_gnt = 1'b0;
    tick();

    // Minimum-latency first fetch.
    fetch(0, 0, 32'h0050_0093, 1'b0);
    chk32("first_instr", instr, 32'h0050_0093);
    chk32("first_pc", pc, 32'h0000_0000);

    // Sequential advance from 0x10 gives 0x14.
    advance(1'b1, 32'h0000_0010, go);
    fetch(1, 1, $urandom, 1'b0);
    advance(1'b0, 32'hDEAD_BEEF, go);
    chk32("seq_addr", imem_addr, 32'h0000_0014);
    fetch(0, 2, $urandom, 1'b0);

    // Branch to 0x100 with pc_inc held during WAIT.
    advance(1'b1, 32'h0000_0100, go);
    chk32("br_addr", imem_addr, 32'h0000_0100);
    fetch(0, 3, $urandom, 1'b1);
    chk32("br_pc_kept", pc, 32'h0000_0100);

    // Grant withheld for three cycles.
    advance(1'b0, 32'h0000_0000, go);
    fetch(3, 1, $urandom, 1'b0);

    // PC+4 wraps at the top of the address space.
    advance(1'b1, 32'hFFFF_FFFC, go);
    fetch(0, 0, $urandom, 1'b0);
    advance(1'b0, 32'h1234_5678, go);
    chk32("wrap_addr", imem_addr, 32'h0000_0000);
    fetch(2, 0, $urandom, 1'b0);

    // Misaligned target, then an aligned one.
    advance(1'b1, 32'h0000_0100, go);
    fetch(0, 0, $urandom, 1'b0);
    advance(1'b1, 32'h0000_0102, go);
    if (go) fetch(0, 1, $urandom, 1'b0);
    advance(1'b1, 32'h0000_0200, go);
    chk1("mis_clear", misalign, 1'b0);
    fetch(1, 0, $urandom, 1'b0);

    // Randomized walk, including idle cycles with select/target noise.
    for (int k = 0; k < 24; k++) begin
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
        pc_sel    = 1'($urandom);
        pc_target = $urandom;
        tick();
        chk32("idle_pc", pc, exp_pc);
        chk1("idle_req", imem_req, 1'b0);
      end
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      advance(1'($urandom), tgt, go);
      if (go) fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, 1'($urandom));
    end

    // Reset mid-fetch, then a late rvalid in REQ must be dropped.
    advance(1'b1, 32'h0000_0400, go);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst      = 1'b1;
    #1;
    chk1("mid_rst_req", imem_req, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk32("mid_rst_pc", pc, 32'h0000_0000);
    chk1("mid_rst_mis", misalign, 1'b0);
    tick();
    rst       = 1'b0;
    exp_pc    = 32'h0000_0000;
    exp_instr = 32'h0000_0013;
    exp_mis   = 1'b0;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADC_0FFE;
    tick();
    imem_rvalid = 1'b0;
    chk1("late_rv_req", imem_req, 1'b1);
    chk1("late_rv_valid", instr_valid, 1'b0);
    chk32("late_rv_instr", instr, 32'h0000_0013);
    fetch(0, 0, 32'h0000_0093, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
